// File: rtl/max_scan_pkg.sv
// Shared defaults and FSM state encoding for the max-scan controller.
package max_scan_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/max_scan_ctrl.sv
// Streams N words from data memory and reports their unsigned maximum.
// The address counter, comparator and FSM all live in this one module.
module max_scan_ctrl
  import max_scan_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [31:0]       len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_out,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic              rd_vld_p1;
  logic              first_p1;
  logic [DATA_W-1:0] run_max_p1;

  // len==0 still scans one word; anything past the address space is clamped.
  function automatic logic [ADDR_W:0] eff_count(input logic [31:0] l);
    logic [63:0] lim;
    lim = 64'd1 << ADDR_W;
    if (l == 32'd0)
      return (ADDR_W+1)'(1);
    else if (64'(l) >= lim)
      return MAX_N;
    else
      return (ADDR_W+1)'(l);
  endfunction

  function automatic logic [DATA_W-1:0] upd_max(input logic first,
                                                input logic [DATA_W-1:0] cur,
                                                input logic [DATA_W-1:0] d);
    return (first || (d > cur)) ? d : cur;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      max_out   <= '0;
      cnt       <= '0;
      rd_vld_p1 <= 1'b0;
      first_p1  <= 1'b0;
    end else begin
      // stage p1: read data returns one cycle behind the strobe
      rd_vld_p1 <= mem_rd;
      done      <= 1'b0;
      if (rd_vld_p1)
        first_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr <= base_addr[ADDR_W-1:0];
            cnt      <= eff_count(len);
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
            first_p1 <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (cnt == (ADDR_W+1)'(1)) begin
            mem_rd <= 1'b0;
            cnt    <= '0;
            state  <= DRAIN;
          end else begin
            mem_addr <= mem_addr + 1'b1;
            cnt      <= cnt - 1'b1;
          end
        end
        DRAIN: begin
          max_out <= upd_max(first_p1, run_max_p1, mem_rdata);
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Running max is pure datapath; the first-word flag makes its reset value irrelevant.
  always_ff @(posedge clk) begin
    if (state == IDLE && start)
      run_max_p1 <= '0;
    else if (rd_vld_p1)
      run_max_p1 <= upd_max(first_p1, run_max_p1, mem_rdata);
  end

endmodule

// File: tb/tb_max_scan_ctrl.sv
// Randomised and directed checks of max_scan_ctrl against a word-array memory model.
module tb_max_scan_ctrl;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int MSIZE  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [31:0]       base_addr;
  logic [31:0]       len;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] max_out;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem [MSIZE];

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_max_out = '0;

  max_scan_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .max_out(max_out), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected result straight from the rules: max over N wrapped addresses.
  function automatic logic [DATA_W-1:0] model_max(input logic [31:0] b, input int n);
    logic [DATA_W-1:0] m;
    m = mem[b[ADDR_W-1:0]];
    for (int i = 1; i < n; i++)
      if (mem[(b + i) % MSIZE] > m) m = mem[(b + i) % MSIZE];
    return m;
  endfunction

  function automatic int model_n(input logic [31:0] l);
    if (l == 0) return 1;
    if (l >= MSIZE) return MSIZE;
    return int'(l);
  endfunction

  // restart_at/rst_at: cycle k during which a second start / reset is driven.
  task automatic scan(input string nm, input logic [31:0] b, input logic [31:0] l,
                      input int restart_at, input int rst_at, input bit noise);
    int n;
    logic [ADDR_W-1:0] last_a;
    logic [DATA_W-1:0] em;
    n  = model_n(l);
    em = model_max(b, n);
    last_a = ADDR_W'((b + n - 1) % MSIZE);
    @(negedge clk);
    base_addr = b; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= n + 3; k++) begin
      if (k > 1) @(negedge clk);
      chk({nm, ".mem_rd"}, 64'(mem_rd), 64'(k <= n));
      if (k <= n) chk({nm, ".addr"}, 64'(mem_addr), 64'((b + k - 1) % MSIZE));
      else        chk({nm, ".addr_hold"}, 64'(mem_addr), 64'(last_a));
      chk({nm, ".done"}, 64'(done), 64'(k == n + 2));
      chk({nm, ".busy"}, 64'(busy), 64'(k <= n + 2));
      if (k == n + 2) begin
        exp_max_out = em;
        chk({nm, ".max_out"}, 64'(max_out), 64'(em));
      end
      start = 1'b0;
      if (noise) begin
        base_addr = $urandom; len = $urandom;
        start = ($urandom_range(0, 3) == 0) && (k <= n + 2);
      end
      if (k == restart_at) begin
        start = 1'b1; base_addr = 32'h100;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_max_out = '0;
        chk({nm, ".rst_busy"}, 64'(busy), 64'd0);
        chk({nm, ".rst_rd"}, 64'(mem_rd), 64'd0);
        chk({nm, ".rst_max"}, 64'(max_out), 64'd0);
        chk({nm, ".rst_addr"}, 64'(mem_addr), 64'd0);
        for (int j = 0; j < n + 3; j++) begin
          chk({nm, ".no_done"}, 64'(done), 64'd0);
          @(negedge clk);
        end
        return;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MSIZE; i++) mem[i] = $urandom;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.mem_rd", 64'(mem_rd), 64'd0);
    chk("reset.mem_addr", 64'(mem_addr), 64'd0);
    chk("reset.max_out", 64'(max_out), 64'd0);

    mem[16'h10] = 5; mem[16'h11] = 9; mem[16'h12] = 3; mem[16'h13] = 7;
    scan("basic", 32'h10, 4, 0, 0, 1'b0);
    chk("basic.value", 64'(max_out), 64'h9);

    mem[16'h20] = 32'hAB;
    scan("len0", 32'h20, 0, 0, 0, 1'b0);
    chk("len0.value", 64'(max_out), 64'hAB);

    mem[16'hFFFE] = 1; mem[16'hFFFF] = 2; mem[16'h0000] = 32'hFFFF_FFFF;
    scan("wrap", 32'hFFFE, 3, 0, 0, 1'b0);
    chk("wrap.value", 64'(max_out), 64'hFFFF_FFFF);

    scan("restart", 32'h0, 8, 3, 0, 1'b0);

    scan("midrst", 32'h40, 8, 0, 3, 1'b0);
    scan("after_rst", 32'h40, 8, 0, 0, 1'b0);

    for (int i = 0; i < 4; i++) mem[i] = 32'h8000_0000;
    scan("equal", 32'h0, 4, 0, 0, 1'b0);
    chk("equal.value", 64'(max_out), 64'h8000_0000);

    for (int t = 0; t < 25; t++) begin
      logic [31:0] rb;
      logic [31:0] rl;
      rb = $urandom;
      rl = $urandom_range(0, 24);
      if (t % 5 == 0) rb = 32'(MSIZE - $urandom_range(1, 6));
      for (int i = 0; i < model_n(rl); i++)
        if ($urandom_range(0, 4) == 0) mem[(rb + i) % MSIZE] = $urandom_range(0, 3) << 30;
      scan("rand", rb, rl, 0, 0, 1'b1);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rand.idle_hold", 64'(max_out), 64'(exp_max_out));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/max_scan_ctrl.md
MAX_SCAN_CTRL -- requirements
Module: max_scan_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, data-memory word-address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin a max scan; sampled only in IDLE.
REQ-006 base_addr  input  32  first word address; only bits [ADDR_W-1:0] used.
REQ-007 len  input  32  number of words to scan.
REQ-008 busy  output  1  high from the cycle after an accepted start through the done cycle.
REQ-009 done  output  1  one-cycle pulse; max_out valid.
REQ-010 max_out  output  DATA_W  scan result; held until the next accepted start.
REQ-011 mem_rd  output  1  read strobe to data memory.
REQ-012 mem_addr  output  ADDR_W  read address to data memory.
REQ-013 mem_rdata  input  DATA_W  read data; valid exactly one cycle after mem_rd.

Function
REQ-014 The FSM SHALL have states IDLE, SCAN, DRAIN, DONE.
REQ-015 IDLE: start=1 SHALL latch base_addr and effective count N, clear the running max, and go to SCAN.
REQ-016 Effective N SHALL be 1 when len==0 and SHALL be min(len, 2**ADDR_W) otherwise; the counter is ADDR_W+1 bits.
REQ-017 SCAN SHALL assert mem_rd for exactly N consecutive cycles with mem_addr = base+i, i=0..N-1, one read per cycle, no bubbles.
REQ-018 Address increment SHALL wrap modulo 2**ADDR_W (0xFFFF+1 -> 0x0000).
REQ-019 Each returned word SHALL be compared as unsigned; running max SHALL take mem_rdata when mem_rdata > max, or unconditionally for the first word (i=0).
REQ-020 After the last read issues, the FSM SHALL enter DRAIN for one cycle to capture the final word, then DONE.
REQ-021 DONE SHALL last one cycle with done=1 and max_out updated; the FSM then returns to IDLE.
REQ-022 Latency: start sampled at edge T -> mem_rd high in cycles T+1..T+N -> done high in cycle T+N+2.
REQ-023 start while busy SHALL be ignored and SHALL NOT change latched base, count, or max.
REQ-024 start in the DONE cycle SHALL be ignored; a new scan is accepted from IDLE only.
REQ-025 mem_rd SHALL be 0 and mem_addr SHALL hold its last value in IDLE, DRAIN, and DONE.
REQ-026 base_addr and len changes after acceptance SHALL NOT affect the scan in progress.

Reset
REQ-027 rst=1 SHALL force IDLE on the next edge, including mid-scan; the scan is aborted and no done is issued.
REQ-028 Reset values: busy=0, done=0, mem_rd=0, mem_addr=0, max_out=0, counter=0.
REQ-029 A read issued in the cycle before reset SHALL have its returned data discarded.

Structure
REQ-030 Package max_scan_pkg SHALL hold ADDR_W/DATA_W defaults and the state enum (IDLE, SCAN, DRAIN, DONE).
REQ-031 The block SHALL be a single module with no sub-module; the comparator, address counter, and FSM are inline.
REQ-032 All outputs SHALL be registered.

Verification
REQ-033 Preload mem[0x10..0x13] = 5, 0x9, 0x3, 0x7; start with base=0x10, len=4 -> mem_rd in 4 cycles at addresses 0x10-0x13; done at T+6; max_out=0x9.
REQ-034 Set mem[0x20]=0xAB; start with len=0 -> one read at 0x20; done at T+3; max_out=0xAB.
REQ-035 Set mem[0xFFFE]=1, mem[0xFFFF]=2, mem[0x0000]=0xFFFFFFFF; start with base=0xFFFE, len=3 -> addresses 0xFFFE, 0xFFFF, 0x0000; max_out=0xFFFFFFFF, which checks the unsigned compare.
REQ-036 Start base=0, len=8, then pulse start again with base=0x100 at T+3 -> second start ignored; one done at T+10 with the result of 0..7.
REQ-037 Assert rst at T+3 of a len=8 scan -> next cycle busy=0, mem_rd=0, max_out=0; no done; a fresh scan afterwards completes correctly.
REQ-038 Fill all words in 0..3 with 0x80000000; start with len=4 -> max_out=0x80000000, which checks the equal-value and first-word load.
